// File: rtl/matrix_row_driver.sv
// Row-side driver for a 5-column LED matrix scan: double-buffered frame storage,
// per-column dwell tick, blanking around column changes and frame-boundary bank swap.
module matrix_row_driver #(
    parameter int unsigned ROWS  = 7,
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [4:0]      column,
    output logic            advance,
    output logic [ROWS-1:0] row,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2:0]      wr_col,
    input  logic [ROWS-1:0] wr_data,
    input  logic            commit,
    output logic            commit_pending,
    output logic            frame_start,
    output logic            col_fault
);

    localparam int unsigned NumCols = 5;
    localparam int unsigned CntW    = $clog2(DWELL);
    localparam int unsigned BlkW    = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
    localparam logic [BlkW-1:0] BlkLoad = BlkW'(BLANK);
    localparam logic [4:0]      LastCol = 5'b10000;

    logic [CntW-1:0] dwell_q, dwell_d;
    logic [BlkW-1:0] blank_q, blank_d;
    logic [4:0]      column_q, column_d;
    logic [ROWS-1:0] row_q, row_d;
    logic            sel_q, sel_d;
    logic            commit_pending_q, commit_pending_d;
    logic            frame_start_q, frame_start_d;
    logic            col_fault_q, col_fault_d;
    logic [ROWS-1:0] bank_q [2][NumCols];
    logic [ROWS-1:0] bank_d [2][NumCols];

    logic            one_hot;
    logic            col_changed;
    logic            swap;
    logic [ROWS-1:0] front_row;

    always_comb begin
        one_hot     = (column != '0) && ((column & (column - 5'd1)) == '0);
        col_changed = (column != column_q);
        advance     = (dwell_q == CntLast);
        wr_ready    = !commit_pending_q;
        // Swap only as the last column is leaving, so a frame is never shown half old/half new.
        swap        = commit_pending_q && advance && (column == LastCol);

        dwell_d  = advance ? '0 : dwell_q + 1'b1;
        column_d = column;

        if (col_changed) begin
            blank_d = BlkLoad;
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end else begin
            blank_d = '0;
        end

        front_row = '0;
        for (int k = 0; k < NumCols; k++) begin
            if (column[k]) begin
                front_row = front_row | bank_q[sel_q][k];
            end
        end
        // Blank on the change edge itself, then until the counter runs out.
        row_d = (one_hot && (blank_d == '0)) ? front_row : '0;

        col_fault_d = col_fault_q | !one_hot;

        bank_d = bank_q;
        if (wr_valid && wr_ready && (wr_col < 3'(NumCols))) begin
            bank_d[!sel_q][wr_col] = wr_data;
        end

        sel_d            = sel_q ^ swap;
        commit_pending_d = (commit_pending_q && !swap) || commit;
        frame_start_d    = swap;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dwell_q          <= '0;
            blank_q          <= '0;
            column_q         <= '0;
            row_q            <= '0;
            sel_q            <= 1'b0;
            commit_pending_q <= 1'b0;
            frame_start_q    <= 1'b0;
            col_fault_q      <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NumCols; k++) begin
                    bank_q[b][k] <= '0;
                end
            end
        end else begin
            dwell_q          <= dwell_d;
            blank_q          <= blank_d;
            column_q         <= column_d;
            row_q            <= row_d;
            sel_q            <= sel_d;
            commit_pending_q <= commit_pending_d;
            frame_start_q    <= frame_start_d;
            col_fault_q      <= col_fault_d;
            bank_q           <= bank_d;
        end
    end

    assign row            = row_q;
    assign commit_pending = commit_pending_q;
    assign frame_start    = frame_start_q;
    assign col_fault      = col_fault_q;

endmodule

// File: tb/tb_matrix_row_driver.sv
// Randomized self-checking bench for matrix_row_driver with a frame-level reference model
// and a few hand-computed expectations from the scan scenarios.
module tb_matrix_row_driver;

    localparam int unsigned ROWS  = 7;
    localparam int unsigned DWELL = 16;
    localparam int unsigned BLANK = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [4:0]      column;
    logic            advance;
    logic [ROWS-1:0] row;
    logic            wr_valid;
    logic            wr_ready;
    logic [2:0]      wr_col;
    logic [ROWS-1:0] wr_data;
    logic            commit;
    logic            commit_pending;
    logic            frame_start;
    logic            col_fault;

    int checks   = 0;
    int failures = 0;
    bit auto_ring = 0;

    matrix_row_driver #(
        .ROWS (ROWS),
        .DWELL(DWELL),
        .BLANK(BLANK)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .column        (column),
        .advance       (advance),
        .row           (row),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_col        (wr_col),
        .wr_data       (wr_data),
        .commit        (commit),
        .commit_pending(commit_pending),
        .frame_start   (frame_start),
        .col_fault     (col_fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int col_idx(input logic [4:0] c);
        for (int k = 0; k < 5; k++) begin
            if (c[k]) return k;
        end
        return 0;
    endfunction

    // Reference model: frames as two plain arrays that trade places on a swap.
    int unsigned     m_edges;
    bit              m_pend;
    logic [4:0]      m_prev_col;
    int unsigned     m_since;
    bit              m_fault;
    logic [ROWS-1:0] m_front [5];
    logic [ROWS-1:0] m_back  [5];
    logic [ROWS-1:0] m_tmp   [5];
    logic [ROWS-1:0] m_row;
    bit              m_fs;
    bit              m_adv_edge;
    bit              m_swap;
    bit              m_onehot;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_edges = 0; m_pend = 0; m_prev_col = '0; m_since = 0; m_fault = 0;
            m_row = '0; m_fs = 0; m_adv_edge = 0;
            for (int k = 0; k < 5; k++) begin
                m_front[k] = '0;
                m_back[k]  = '0;
            end
        end else begin
            m_adv_edge = ((m_edges % DWELL) == DWELL - 1);
            m_onehot   = ($countones(column) == 1);
            if (column != m_prev_col) m_since = 0;
            else if (m_since < 1000) m_since++;
            m_prev_col = column;
            if (!m_onehot) m_fault = 1;
            m_row = (m_onehot && m_since >= BLANK) ? m_front[col_idx(column)] : '0;
            if (wr_valid && !m_pend && wr_col < 3'd5) m_back[wr_col] = wr_data;
            m_swap = m_pend && m_adv_edge && (column == 5'b10000);
            m_fs   = m_swap;
            if (m_swap) begin
                m_tmp = m_front; m_front = m_back; m_back = m_tmp;
                m_pend = 0;
            end
            if (commit) m_pend = 1;
            m_edges++;
        end
    end

    always @(negedge clock) begin
        chk("advance", 32'(advance), 32'((m_edges % DWELL) == DWELL - 1));
        chk("row", 32'(row), 32'(m_row));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
        chk("commit_pending", 32'(commit_pending), 32'(m_pend));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("col_fault", 32'(col_fault), 32'(m_fault));
    end

    task automatic step_cycle();
        @(posedge clock);
        #1;
        if (auto_ring && m_adv_edge) column = {column[3:0], column[4]};
    endtask

    task automatic wait_frame_start(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (frame_start) seen = 1;
            else step_cycle();
        end
        chk(name, 32'(seen), 32'(1));
    endtask

    initial begin
        int nz;
        int fs_cnt;
        bit done;
        reset = 1'b1; column = 5'b00001; wr_valid = 0; wr_col = '0; wr_data = '0; commit = 0;
        repeat (3) step_cycle();
        @(negedge clock);
        chk("rst_wr_ready", 32'(wr_ready), 32'(1));
        chk("rst_row", 32'(row), 32'(0));
        step_cycle();
        reset = 1'b0;

        // Advance on edges 15, 31, 47 counting the first post-reset edge as 0.
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            chk("adv_literal", 32'(advance), 32'(i == 15 || i == 31 || i == 47));
            chk("row_idle", 32'(row), 32'(0));
            step_cycle();
        end

        // Fill the back buffer, commit, then scan a frame.
        auto_ring = 1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_col = 3'(i); wr_data = ROWS'(1 << i);
            step_cycle();
        end
        wr_valid = 0; commit = 1;
        step_cycle();
        commit = 0;
        wait_frame_start("fs_after_commit");
        nz = 0;
        for (int i = 0; i < 90; i++) begin
            step_cycle();
            @(negedge clock);
            if (row != '0) begin
                nz++;
                chk("disp_literal", 32'(row), 32'(1) << col_idx(m_prev_col));
            end
        end
        chk("disp_seen", 32'(nz > 40), 32'(1));

        // Writes are held off while a commit is pending.
        step_cycle();
        commit = 1;
        step_cycle();
        commit = 0; wr_valid = 1; wr_col = 3'd2; wr_data = 7'h55;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (frame_start) begin
                done = 1;
                chk("wr_ready_after_swap", 32'(wr_ready), 32'(1));
            end else begin
                chk("wr_blocked", 32'(wr_ready), 32'(0));
                step_cycle();
            end
        end
        chk("swap_seen", 32'(done), 32'(1));
        step_cycle();
        wr_valid = 0;

        // Out-of-range column write is swallowed.
        wr_valid = 1; wr_col = 3'd6; wr_data = 7'h7F;
        step_cycle();
        wr_valid = 0; commit = 1;
        step_cycle();
        commit = 0;
        wait_frame_start("fs_after_bad_col");
        for (int i = 0; i < 90; i++) begin
            step_cycle();
            @(negedge clock);
            chk("no_7f", 32'(row == 7'h7F), 32'(0));
        end

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            step_cycle();
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_col   = 3'($urandom_range(0, 7));
            wr_data  = ROWS'($urandom);
            commit   = ($urandom_range(0, 19) == 0);
        end
        step_cycle();
        wr_valid = 0; commit = 0;

        // Multi-hot column: row blanks and the fault sticks.
        auto_ring = 0;
        column = 5'b00011;
        step_cycle();
        column = 5'b00001;
        @(negedge clock);
        chk("fault_row", 32'(row), 32'(0));
        chk("fault_set", 32'(col_fault), 32'(1));
        repeat (5) step_cycle();
        @(negedge clock);
        chk("fault_sticky", 32'(col_fault), 32'(1));

        // Reset mid-dwell with a commit pending drops the commit.
        auto_ring = 1;
        step_cycle();
        commit = 1;
        step_cycle();
        commit = 0;
        repeat (5) step_cycle();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_adv", 32'(advance), 32'(0));
        chk("rst_row2", 32'(row), 32'(0));
        chk("rst_ready2", 32'(wr_ready), 32'(1));
        chk("rst_pend", 32'(commit_pending), 32'(0));
        chk("rst_fs", 32'(frame_start), 32'(0));
        chk("rst_fault", 32'(col_fault), 32'(0));
        step_cycle();
        reset = 1'b0;
        fs_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step_cycle();
            @(negedge clock);
            if (frame_start) fs_cnt++;
        end
        chk("no_fs_after_reset", 32'(fs_cnt), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
